// File: rtl/safe_lockout_controller_pkg.sv
// Shared display-mode codes and helpers for the safe lockout controller.
package safe_lockout_controller_pkg;

  localparam logic [2:0] MODE_BLANK   = 3'd0;
  localparam logic [2:0] MODE_ENTER   = 3'd1;
  localparam logic [2:0] MODE_ERROR   = 3'd2;
  localparam logic [2:0] MODE_LOCKOUT = 3'd3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/safe_wait_timer.sv
// Loadable down-counter for the message and lockout waits; holds at zero once expired.
module safe_wait_timer #(
  parameter int unsigned TMR_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             expired
);

  logic [TMR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/safe_lockout_controller.sv
// Safe lock control FSM with internal message timer, failed-attempt counter and timed lockout.
// Lockout is enabled by defining SAFE_LOCKOUT_EN; otherwise wrong codes only show ERROR.
module safe_lockout_controller
  import safe_lockout_controller_pkg::*;
#(
  parameter int unsigned MSG_CYCLES     = 8,
  parameter int unsigned LOCKOUT_CYCLES = 32,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned TRY_W          = $clog2(MAX_TRIES + 1),
  parameter int unsigned TMR_W          = $clog2(max_u(MSG_CYCLES, LOCKOUT_CYCLES) + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             done,
  input  logic             match,
  input  logic             cancel,
  output logic             clear_entry,
  output logic             accept_digit,
  output logic             load_code,
  output logic [2:0]       display_mode,
  output logic             lock,
  output logic [TRY_W-1:0] fail_count,
  output logic             locked_out
);

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    UClear      = 3'd0,
    UEntry      = 3'd1,
    Store       = 3'd2,
    LClear      = 3'd3,
    LEntry      = 3'd4,
    OkWait      = 3'd5,
    ErrWait     = 3'd6,
    LockoutWait = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [TRY_W-1:0] fail_q, fail_d, fail_inc;
  logic             tmr_load, tmr_expired, hit_lockout;
  logic [TMR_W-1:0] tmr_val;

  safe_wait_timer #(
    .TMR_W(TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .expired (tmr_expired)
  );

  assign fail_inc = (fail_q == TRY_W'(MAX_TRIES)) ? fail_q : fail_q + 1'b1;

`ifdef SAFE_LOCKOUT_EN
  assign hit_lockout = (fail_inc == TRY_W'(MAX_TRIES));
`else
  assign hit_lockout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      UClear: state_d = UEntry;
      UEntry: begin
        if (done) begin
          state_d = Store;
        end else if (cancel) begin
          state_d = UClear;
        end
      end
      Store:  state_d = LClear;
      LClear: state_d = LEntry;
      LEntry: begin
        if (done) begin
          tmr_load = 1'b1;
          if (match) begin
            fail_d  = '0;
            state_d = OkWait;
            tmr_val = TMR_W'(MSG_CYCLES - 1);
          end else begin
            fail_d = fail_inc;
            if (hit_lockout) begin
              state_d = LockoutWait;
              tmr_val = TMR_W'(LOCKOUT_CYCLES - 1);
            end else begin
              state_d = ErrWait;
              tmr_val = TMR_W'(MSG_CYCLES - 1);
            end
          end
        end else if (cancel) begin
          state_d = LClear;
        end
      end
      OkWait:  if (tmr_expired) state_d = UClear;
      ErrWait: if (tmr_expired) state_d = LClear;
      LockoutWait: begin
        if (tmr_expired) begin
          state_d = LClear;
          fail_d  = '0;
        end
      end
      default: state_d = UClear;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UClear;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
    end
  end

  // Moore outputs decoded from the registered state only.
  always_comb begin
    clear_entry  = 1'b0;
    accept_digit = 1'b0;
    load_code    = 1'b0;
    display_mode = MODE_BLANK;
    lock         = 1'b1;
    unique case (state_q)
      UClear: begin
        clear_entry = 1'b1;
        lock        = 1'b0;
      end
      UEntry: begin
        accept_digit = 1'b1;
        display_mode = MODE_ENTER;
        lock         = 1'b0;
      end
      Store:       load_code    = 1'b1;
      LClear:      clear_entry  = 1'b1;
      LEntry: begin
        accept_digit = 1'b1;
        display_mode = MODE_ENTER;
      end
      OkWait:      display_mode = MODE_ENTER;
      ErrWait:     display_mode = MODE_ERROR;
      LockoutWait: display_mode = MODE_LOCKOUT;
      default: begin
        clear_entry = 1'b1;
        lock        = 1'b0;
      end
    endcase
  end

`ifdef SAFE_LOCKOUT_EN
  assign locked_out = (state_q == LockoutWait);
`else
  assign locked_out = 1'b0;
`endif

  assign fail_count = fail_q;

endmodule

// File: doc/safe_lockout_controller.md
# safe_lockout_controller

Parametrised next-generation control FSM for the digital safe lock. It sequences code entry, locking, verification and unlocking, and adds three things: an internal message/lockout timer (replacing the external `start_timer`/`timer_done` handshake), a failed-attempt counter with timed lockout, and a `cancel` input that restarts entry. It sits between the keypad entry/compare datapath (`done`, `match`) and the display and lock actuator.

## Interface
Parameters:
- MSG_CYCLES, default 8: number of cycles that the success and error messages are held; must be ≥1.
- LOCKOUT_CYCLES, default 32: number of cycles the lockout is held; must be ≥1.
- MAX_TRIES, default 3: number of consecutive wrong codes that trigger lockout; must be ≥1.
- TRY_W, default $clog2(MAX_TRIES+1): width of the attempt counter.
- TMR_W, default $clog2(max(MSG_CYCLES,LOCKOUT_CYCLES)+1): width of the timer.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- done  in  1  one-cycle pulse: entry complete
- match  in  1  entered code equals stored code; valid only when `done`=1
- cancel  in  1  one-cycle pulse: abandon the current entry
- clear_entry  out  1  clear the entry register
- accept_digit  out  1  entry datapath may take digits
- load_code  out  1  store the current entry as the code
- display_mode  out  3  one of the `MODE_*` values
- lock  out  1  1 = bolt engaged
- fail_count  out  TRY_W  number of consecutive wrong attempts
- locked_out  out  1  1 while in lockout

## Operation
- Moore outputs are decoded from the registered state. States and their outputs:
  - U_CLEAR: clear_entry=1, BLANK, lock=0. Next state: U_ENTRY.
  - U_ENTRY: accept_digit=1, ENTER, lock=0. On done → STORE. On cancel (without done) → U_CLEAR.
  - STORE: load_code=1, BLANK, lock=1. Next state: L_CLEAR.
  - L_CLEAR: clear_entry=1, BLANK, lock=1. Next state: L_ENTRY.
  - L_ENTRY: accept_digit=1, ENTER, lock=1. On cancel (without done) → L_CLEAR. On done:
    - match=1 → OK_WAIT.
    - match=0 → ERR_WAIT, or LOCKOUT_WAIT if the increment makes fail_count reach MAX_TRIES.
  - OK_WAIT: ENTER, lock=1. When the timer expires → U_CLEAR.
  - ERR_WAIT: ERROR, lock=1. When the timer expires → L_CLEAR.
  - LOCKOUT_WAIT: `MODE_LOCKOUT`, lock=1, locked_out=1. When the timer expires → L_CLEAR.
- An illegal state encoding recovers to U_CLEAR.
- fail_count rules:
  - Cleared to 0 on a correct done.
  - Incremented on a wrong done, saturating at MAX_TRIES.
  - Cleared to 0 on the cycle LOCKOUT_WAIT exits.
  - Not changed by cancel.
- Simultaneous events:
  - done and cancel in the same cycle: done wins, and cancel is ignored.
  - done and cancel are ignored in every state except U_ENTRY and L_ENTRY.
  - match is ignored when done=0.

## Timing
- Reset: state=U_CLEAR, timer=0, fail_count=0. Outputs during and after reset: clear_entry=1, accept_digit=0, load_code=0, display=BLANK, lock=0, locked_out=0.
- Reset mid-operation, including during lockout, returns to the reset values immediately. Retention of the stored code is outside this block.
- Transition latency: a done or cancel pulse sampled at edge k produces the new state's outputs after edge k.
- Timer behaviour:
  - Loaded with duration−1 on the edge that enters a wait state.
  - Decrements while nonzero.
  - The state exits on the edge at which the timer is 0.
  - Result: OK_WAIT and ERR_WAIT last exactly MSG_CYCLES cycles, and LOCKOUT_WAIT lasts exactly LOCKOUT_CYCLES cycles.
- Timer arithmetic is unsigned TMR_W bits and never underflows; it holds at 0 outside the wait states.
- Every STORE, U_CLEAR and L_CLEAR visit lasts exactly 1 cycle.

## Configuration
- `SAFE_LOCKOUT_EN` defined: lockout behaviour exactly as described above.
- `SAFE_LOCKOUT_EN` undefined:
  - LOCKOUT_WAIT is unreachable, and a wrong done always goes to ERR_WAIT.
  - fail_count still counts and saturates at MAX_TRIES.
  - locked_out is tied to 0.
  - LOCKOUT_CYCLES is unused.

## Structure
- The `MODE_BLANK`, `MODE_ENTER` and `MODE_ERROR` constants stay in the team params include. The new `MODE_LOCKOUT` code is added to the same header and must be distinct from the other modes.
- The state encoding is a localparam inside the module.
- One sub-module, `safe_wait_timer`, is a natural split:
  - Loadable down-counter.
  - Inputs: load, load_val[TMR_W-1:0].
  - Output: expired, meaning count==0.

## Test plan
- Program and open: reset, done in U_ENTRY → STORE asserts load_code for 1 cycle with lock=1; done with match=1 in L_ENTRY → OK_WAIT lasts 8 cycles, then U_CLEAR with lock=0 and fail_count=0.
- Wrong code: done with match=0 → ERR_WAIT lasts 8 cycles with display=ERROR, fail_count=1, then L_CLEAR → L_ENTRY.
- Lockout (`SAFE_LOCKOUT_EN`): 3 wrong codes → the third enters LOCKOUT_WAIT; locked_out=1 for exactly 32 cycles; fail_count=3, then 0 on exit; done pulses during lockout are ignored.
- No-lockout build: 5 wrong codes → ERR_WAIT each time, fail_count saturates at 3, locked_out is never 1.
- Cancel: cancel in L_ENTRY → L_CLEAR (clear_entry=1 for 1 cycle) with fail_count unchanged; done and cancel in the same cycle with match=1 → OK_WAIT.
- Asynchronous reset asserted mid-LOCKOUT_WAIT → outputs return to the reset values immediately; after release, fail_count=0, state is U_CLEAR, lock=0.
